// File: rtl/mul_div_scheduler.sv
// Multiply/divide sequencer for the EX stage: issues one request to the pipelined
// multiplier or the iterative divider and holds the HI/LO result until EX consumes it.
module mul_div_scheduler #(
    parameter int unsigned CPU_DATA_WIDTH   = 32,
    parameter int unsigned MULTIPLY_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,

    input  logic                          request_valid,
    output logic                          request_ready,
    input  logic                          request_is_divide,
    input  logic                          request_signed,
    input  logic [CPU_DATA_WIDTH-1:0]     source1,
    input  logic [CPU_DATA_WIDTH-1:0]     source2,

    output logic                          multiplier_valid,
    output logic                          multiplier_signed,
    output logic [CPU_DATA_WIDTH-1:0]     multiplier_source1,
    output logic [CPU_DATA_WIDTH-1:0]     multiplier_source2,
    input  logic [2*CPU_DATA_WIDTH-1:0]   multiplier_result,

    output logic                          divider_valid,
    input  logic                          divider_ready,
    output logic                          divider_signed,
    output logic [CPU_DATA_WIDTH-1:0]     divider_dividend,
    output logic [CPU_DATA_WIDTH-1:0]     divider_divisor,
    output logic                          divider_abort,
    input  logic                          divider_result_valid,
    input  logic [CPU_DATA_WIDTH-1:0]     divider_quotient,
    input  logic [CPU_DATA_WIDTH-1:0]     divider_remainder,

    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [CPU_DATA_WIDTH-1:0]     result_high,
    output logic [CPU_DATA_WIDTH-1:0]     result_low,
    output logic                          busy
);

    localparam int unsigned W = CPU_DATA_WIDTH;
    localparam logic [2:0] LatencyCount = 3'(MULTIPLY_LATENCY);

    typedef enum logic [2:0] {
        StIdle,
        StMulWait,
        StDivIssue,
        StDivWait,
        StResult
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     count_q, count_d;
    logic           div_signed_q, div_signed_d;
    logic [W-1:0]   dividend_q, dividend_d;
    logic [W-1:0]   divisor_q, divisor_d;
    logic [W-1:0]   high_q, high_d;
    logic [W-1:0]   low_q, low_d;

    logic           accept;
    logic           accept_mul;

    // Gating with reset keeps every output at zero while reset is held.
    assign request_ready = (state_q == StIdle) & ~flush & ~reset;
    assign accept        = request_valid & request_ready;
    assign accept_mul    = accept & ~request_is_divide;

    assign multiplier_valid   = accept_mul;
    assign multiplier_signed  = accept_mul & request_signed;
    assign multiplier_source1 = accept_mul ? source1 : '0;
    assign multiplier_source2 = accept_mul ? source2 : '0;

    assign divider_signed   = div_signed_q;
    assign divider_dividend = dividend_q;
    assign divider_divisor  = divisor_q;

    assign result_valid = (state_q == StResult);
    assign result_high  = high_q;
    assign result_low   = low_q;
    assign busy         = (state_q != StIdle);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        div_signed_d  = div_signed_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        high_d        = high_q;
        low_d         = low_q;
        divider_valid = 1'b0;
        divider_abort = 1'b0;

        if (flush) begin
            // Flush drops everything in flight; the divider is told to forget its operands.
            state_d       = StIdle;
            divider_abort = (state_q == StDivIssue) || (state_q == StDivWait);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!request_is_divide) begin
                            state_d = StMulWait;
                            count_d = 3'd1;
                        end else if (source2 == '0) begin
                            // Divide by zero never reaches the divider.
                            state_d = StResult;
                            high_d  = source1;
                            low_d   = '1;
                        end else begin
                            state_d      = StDivIssue;
                            div_signed_d = request_signed;
                            dividend_d   = source1;
                            divisor_d    = source2;
                        end
                    end
                end
                StMulWait: begin
                    if (count_q == LatencyCount) begin
                        state_d = StResult;
                        high_d  = multiplier_result[2*W-1:W];
                        low_d   = multiplier_result[W-1:0];
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end
                StDivIssue: begin
                    divider_valid = 1'b1;
                    if (divider_ready) begin
                        state_d = StDivWait;
                    end
                end
                StDivWait: begin
                    if (divider_result_valid) begin
                        state_d = StResult;
                        high_d  = divider_remainder;
                        low_d   = divider_quotient;
                    end
                end
                StResult: begin
                    if (result_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= 3'd0;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            high_q       <= '0;
            low_q        <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            div_signed_q <= div_signed_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            high_q       <= high_d;
            low_q        <= low_d;
        end
    end

endmodule

// File: tb/tb_mul_div_scheduler.sv
// Randomised bench for mul_div_scheduler with behavioural multiplier/divider models and an
// arithmetic reference for HI/LO results and handshake timing.
module tb_mul_div_scheduler;

    localparam int LAT = 2;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        request_valid;
    logic        request_ready;
    logic        request_is_divide;
    logic        request_signed;
    logic [31:0] source1;
    logic [31:0] source2;
    logic        multiplier_valid;
    logic        multiplier_signed;
    logic [31:0] multiplier_source1;
    logic [31:0] multiplier_source2;
    logic [63:0] multiplier_result;
    logic        divider_valid;
    logic        divider_ready;
    logic        divider_signed;
    logic [31:0] divider_dividend;
    logic [31:0] divider_divisor;
    logic        divider_abort;
    bit          divider_result_valid;
    bit   [31:0] divider_quotient;
    bit   [31:0] divider_remainder;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_high;
    logic [31:0] result_low;
    logic        busy;

    mul_div_scheduler #(
        .CPU_DATA_WIDTH   (32),
        .MULTIPLY_LATENCY (LAT)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .flush                (flush),
        .request_valid        (request_valid),
        .request_ready        (request_ready),
        .request_is_divide    (request_is_divide),
        .request_signed       (request_signed),
        .source1              (source1),
        .source2              (source2),
        .multiplier_valid     (multiplier_valid),
        .multiplier_signed    (multiplier_signed),
        .multiplier_source1   (multiplier_source1),
        .multiplier_source2   (multiplier_source2),
        .multiplier_result    (multiplier_result),
        .divider_valid        (divider_valid),
        .divider_ready        (divider_ready),
        .divider_signed       (divider_signed),
        .divider_dividend     (divider_dividend),
        .divider_divisor      (divider_divisor),
        .divider_abort        (divider_abort),
        .divider_result_valid (divider_result_valid),
        .divider_quotient     (divider_quotient),
        .divider_remainder    (divider_remainder),
        .result_valid         (result_valid),
        .result_ready         (result_ready),
        .result_high          (result_high),
        .result_low           (result_low),
        .busy                 (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // HI/LO as the instruction set defines them: {product} or {remainder, quotient}.
    function automatic logic [63:0] ref_op(input logic is_div, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (!is_div) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Multiplier model: product appears LAT cycles after the start pulse, noise otherwise.
    bit [63:0] mpipe [LAT];
    bit        mvld  [LAT];
    bit [63:0] noise;
    always @(posedge clock) begin
        mpipe[0] <= ref_op(1'b0, multiplier_signed, multiplier_source1, multiplier_source2);
        mvld[0]  <= multiplier_valid;
        for (int i = 1; i < LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
            mvld[i]  <= mvld[i-1];
        end
        noise <= {$urandom, $urandom};
    end
    assign multiplier_result = mvld[LAT-1] ? mpipe[LAT-1] : noise;

    // Divider model with programmable accept and compute delays.
    int unsigned rdy_delay = 0;
    int unsigned calc_delay = 5;
    bit          ignore_abort = 1'b0;
    int unsigned rdy_cnt = 0;
    int unsigned calc_cnt = 0;
    bit          calc_busy = 1'b0;
    bit [63:0]   calc_res;

    assign divider_ready = divider_valid && (rdy_cnt >= rdy_delay);

    always @(posedge clock) begin
        divider_result_valid <= 1'b0;
        divider_quotient     <= $urandom;
        divider_remainder    <= $urandom;
        if (divider_valid && divider_ready) begin
            rdy_cnt   <= 0;
            calc_busy <= 1'b1;
            calc_cnt  <= calc_delay;
            calc_res  <= ref_op(1'b1, divider_signed, divider_dividend, divider_divisor);
        end else if (divider_valid) begin
            rdy_cnt <= rdy_cnt + 1;
        end else begin
            rdy_cnt <= 0;
        end
        if (divider_abort && !ignore_abort) begin
            calc_busy <= 1'b0;
            rdy_cnt   <= 0;
        end else if (calc_busy) begin
            if (calc_cnt == 0) begin
                divider_result_valid <= 1'b1;
                divider_quotient     <= calc_res[31:0];
                divider_remainder    <= calc_res[63:32];
                calc_busy            <= 1'b0;
            end else begin
                calc_cnt <= calc_cnt - 1;
            end
        end
    end

    logic [31:0] exp_a, exp_b;
    logic        exp_sgn;
    int          div_valid_cycles = 0;
    int          abort_cycles = 0;

    task automatic mon();
        if (divider_valid) begin
            div_valid_cycles++;
            check("div_operands", 96'({divider_signed, divider_dividend, divider_divisor}),
                  96'({exp_sgn, exp_a, exp_b}));
        end
        if (divider_abort) abort_cycles++;
    endtask

    task automatic wait_neg();
        @(negedge clock);
        mon();
    endtask

    task automatic wait_pos();
        @(posedge clock);
        #1;
    endtask

    // Issue one request at the start of an idle cycle and follow it to completion.
    task automatic run_op(input logic is_div, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int stall);
        logic [63:0] exp;
        logic        dz;
        int          cyc;
        exp = ref_op(is_div, sgn, a, b);
        dz  = is_div && (b == 32'd0);
        exp_a = a; exp_b = b; exp_sgn = sgn;
        div_valid_cycles = 0;
        request_valid = 1'b1; request_is_divide = is_div; request_signed = sgn;
        source1 = a; source2 = b; result_ready = 1'b0;
        wait_neg();
        check("request_ready", 96'(request_ready), 96'(1));
        check("mul_valid", 96'(multiplier_valid), 96'(!is_div));
        check("mul_operands", 96'({multiplier_signed, multiplier_source1, multiplier_source2}),
              is_div ? 96'(0) : 96'({sgn, a, b}));
        wait_pos();
        request_valid = 1'b0; source1 = $urandom; source2 = $urandom;
        request_signed = 1'($urandom); request_is_divide = 1'($urandom);
        cyc = 1;
        wait_neg();
        while (!result_valid && cyc < 200) begin
            wait_pos();
            wait_neg();
            cyc++;
        end
        check("result_valid", 96'(result_valid), 96'(1));
        if (!is_div) check("mul_latency", 96'(cyc), 96'(LAT + 1));
        if (dz) check("dz_latency", 96'(cyc), 96'(1));
        check("result", 96'({result_high, result_low}), 96'(exp));
        check("div_valid_cycles", 96'(div_valid_cycles),
              (is_div && !dz) ? 96'(rdy_delay + 1) : 96'(0));
        for (int s = 0; s < stall; s++) begin
            wait_pos();
            source1 = $urandom; source2 = $urandom;
            request_valid = 1'($urandom); request_is_divide = 1'($urandom);
            wait_neg();
            check("stall_hold", 96'({result_valid, request_ready, busy, result_high, result_low}),
                  96'({3'b101, exp}));
        end
        wait_pos();
        request_valid = 1'b0; result_ready = 1'b1;
        wait_neg();
        check("consume_cycle", 96'({result_valid, result_high, result_low}), 96'({1'b1, exp}));
        wait_pos();
        result_ready = 1'b0;
        wait_neg();
        check("idle_after", 96'({busy, result_valid, request_ready}), 96'(3'b001));
        wait_pos();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    int          bad;
    logic [63:0] last;
    logic        r_div, r_sgn;
    logic [31:0] r_a, r_b;

    initial begin
        reset = 1'b1; flush = 1'b0; request_valid = 1'b1; request_is_divide = 1'b0;
        request_signed = 1'b0; source1 = 32'h1234; source2 = 32'h5678; result_ready = 1'b0;
        #3;
        check("reset_outputs", 96'({request_ready, multiplier_valid, divider_valid, divider_abort,
              result_valid, busy, result_high, result_low}), 96'(0));
        wait_pos();
        reset = 1'b0; request_valid = 1'b0;
        wait_neg();
        check("ready_after_reset", 96'({request_ready, busy}), 96'(2'b10));
        wait_pos();

        // Directed cases
        run_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 0);
        rdy_delay = 2; calc_delay = 30;
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'd0, 0);
        rdy_delay = 0; calc_delay = 3;
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 0);
        run_op(1'b0, 1'b0, $urandom, $urandom, 4);
        last = ref_op(1'b0, 1'b0, exp_a, exp_b);

        // Flush five cycles into DIV_WAIT; the divider model keeps going and answers late.
        rdy_delay = 0; calc_delay = 6; ignore_abort = 1'b1; abort_cycles = 0;
        exp_a = 32'd1000; exp_b = 32'd3; exp_sgn = 1'b0;
        request_valid = 1'b1; request_is_divide = 1'b1; request_signed = 1'b0;
        source1 = 32'd1000; source2 = 32'd3;
        wait_neg();
        check("flush_div_accept", 96'(request_ready), 96'(1));
        wait_pos();
        request_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_neg();
            check("div_busy", 96'({busy, result_valid}), 96'(2'b10));
            wait_pos();
        end
        flush = 1'b1; request_valid = 1'b1; request_is_divide = 1'b0;
        source1 = 32'd5; source2 = 32'd6;
        wait_neg();
        check("flush_abort", 96'({divider_abort, divider_valid, request_ready, multiplier_valid}),
              96'(4'b1000));
        wait_pos();
        flush = 1'b0; request_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            wait_neg();
            bad += int'(result_valid | busy | divider_abort);
            wait_pos();
        end
        check("stale_result_ignored", 96'(bad), 96'(0));
        check("abort_single_pulse", 96'(abort_cycles), 96'(1));
        check("regs_after_flush", 96'({result_high, result_low}), 96'(last));
        ignore_abort = 1'b0;
        run_op(1'b0, 1'b0, 32'd7, 32'd9, 0);

        // Flush a multiply in MUL_WAIT; the late product must not land.
        last = 64'd63;
        request_valid = 1'b1; request_is_divide = 1'b0; request_signed = 1'b0;
        source1 = 32'hDEAD_BEEF; source2 = 32'h10;
        wait_neg();
        wait_pos();
        request_valid = 1'b0; flush = 1'b1;
        wait_neg();
        wait_pos();
        flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            wait_neg();
            bad += int'(result_valid | busy);
            wait_pos();
        end
        check("mul_flush_dropped", 96'(bad), 96'(0));
        check("mul_flush_regs", 96'({result_high, result_low}), 96'(last));

        // Flush together with result_ready in RESULT.
        request_valid = 1'b1; request_is_divide = 1'b1; source1 = 32'd9; source2 = 32'd0;
        wait_neg();
        wait_pos();
        request_valid = 1'b0; flush = 1'b1; result_ready = 1'b1;
        wait_neg();
        check("flush_in_result", 96'({result_valid, result_high, result_low}),
              96'({1'b1, 32'd9, 32'hFFFF_FFFF}));
        wait_pos();
        flush = 1'b0; result_ready = 1'b0;
        wait_neg();
        check("idle_after_result_flush", 96'({busy, result_valid, request_ready}), 96'(3'b001));
        wait_pos();

        // Asynchronous reset in the middle of MUL_WAIT.
        request_valid = 1'b1; request_is_divide = 1'b0; source1 = 32'd11; source2 = 32'd13;
        wait_neg();
        wait_pos();
        request_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", 96'({request_ready, multiplier_valid, divider_valid,
              divider_abort, result_valid, busy, result_high, result_low}), 96'(0));
        check("async_reset_div_ops", 96'({divider_signed, divider_dividend, divider_divisor}),
              96'(0));
        #3 reset = 1'b0;
        wait_pos();
        wait_neg();
        check("ready_after_async_reset", 96'({request_ready, busy, result_valid}), 96'(3'b100));
        wait_pos();

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            r_div = 1'($urandom);
            r_sgn = 1'($urandom);
            r_a = pick();
            r_b = pick();
            if (r_div && r_b == 32'd0 && $urandom_range(0, 1) == 0) r_b = 32'd5;
            rdy_delay  = $urandom_range(0, 3);
            calc_delay = $urandom_range(0, 20);
            run_op(r_div, r_sgn, r_a, r_b, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_scheduler.md
Name: mul_div_scheduler

Overview:
- Sequences the shared multiply/divide resources for the EX stage.
- Accepts one MULT/MULTU/DIV/DIVU request at a time over a valid/ready handshake.
- Dispatches the request to the pipelined multiplier or to the iterative divider, then collects the result.
- Holds the 64-bit HI/LO result until the EX stage consumes it; aborts in-flight work on a WB exception/ERET flush.

Parameters:
- CPU_DATA_WIDTH, 32, operand width; matches cpu_core_params.
- MULTIPLY_LATENCY, 2, cycles from multiplier_valid to a valid multiplier_result; legal range 1..7.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  WB exception_valid | eret_flush
- request_valid  in  1  EX presents a mul/div request
- request_ready  out  1  scheduler accepts the request this cycle
- request_is_divide  in  1  1 = divide, 0 = multiply
- request_signed  in  1  signed operation
- source1  in  32  multiplicand / dividend
- source2  in  32  multiplier / divisor
- multiplier_valid  out  1  start pulse to the multiplier
- multiplier_signed  out  1  signedness for the multiplier
- multiplier_source1  out  32  multiplier operand
- multiplier_source2  out  32  multiplier operand
- multiplier_result  in  64  product, valid MULTIPLY_LATENCY cycles after the start pulse
- divider_valid  out  1  divide request to the divider
- divider_ready  in  1  divider accepts the request
- divider_signed  out  1  signedness for the divider
- divider_dividend  out  32  divider operand
- divider_divisor  out  32  divider operand
- divider_abort  out  1  one-cycle cancel; divider returns to its waiting state
- divider_result_valid  in  1  quotient/remainder valid
- divider_quotient  in  32  divider result
- divider_remainder  in  32  divider result
- result_valid  out  1  HI/LO result available
- result_ready  in  1  EX consumes the result
- result_high  out  32  HI value
- result_low  out  32  LO value
- busy  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous): state IDLE; every output 0; captured operands and result registers 0.
- States: IDLE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, RESULT.
- request_ready = (state==IDLE) & !flush. A request is accepted when request_valid & request_ready.
- Multiply accept:
  - multiplier_valid = accept & !request_is_divide, combinational for one cycle.
  - multiplier_source1/2 and multiplier_signed pass source1/2 and request_signed through in that cycle.
  - Next state is MUL_WAIT; the counter loads 1.
  - MUL_WAIT increments the counter each cycle. When counter==MULTIPLY_LATENCY, capture high=result[63:32], low=result[31:0] and go to RESULT.
  - Default timing: accept in cycle 0, result_valid from cycle 3.
- Divide accept with source2 != 0:
  - Latch operands and signedness, then go to DIV_ISSUE.
  - DIV_ISSUE holds divider_valid=1 with stable registered operands until divider_ready, then goes to DIV_WAIT.
  - If divider_ready=1 in the first DIV_ISSUE cycle, the move to DIV_WAIT happens that same cycle.
  - DIV_WAIT: on divider_result_valid, capture high=remainder, low=quotient and go to RESULT.
- Divide by zero is handled without the divider: capture high=source1, low=32'hFFFF_FFFF and go straight to RESULT (result_valid in cycle 1).
- RESULT:
  - result_valid=1; result_high/low are registered and held stable while result_ready=0.
  - result_ready=1 returns to IDLE. A new request can be accepted the following cycle; there is no same-cycle bypass.
- Flush, highest priority:
  - From any state, the next state is IDLE and result_valid drops the next cycle.
  - A request presented in the flush cycle is not accepted.
  - In DIV_ISSUE or DIV_WAIT, divider_abort=1 for exactly the flush cycle, and divider_valid is forced to 0 in that cycle.
  - A divider_result_valid arriving after the flush is ignored.
  - A multiply in flight is dropped; a late product is never captured.
- Simultaneous events:
  - flush together with divider_result_valid: flush wins, no capture.
  - flush together with result_ready in RESULT: state goes to IDLE with no extra effect.
- busy = state != IDLE. EX uses it to stall MFHI/MFLO and any following mul/div.
- Widths: no arithmetic is done here except the 3-bit latency counter; the counter never wraps because it resets on every accept.

Test Plan:
- Signed multiply 0xFFFF_FFFE × 0x0000_0003 with a model multiplier (latency 2) and result_ready held 1 -> multiplier_valid pulses in cycle 0; result_valid in cycle 3 with high=0xFFFF_FFFF, low=0xFFFF_FFFA; IDLE in cycle 4.
- Unsigned divide 100/7; divider_ready delayed 2 cycles; result after 33 cycles -> divider_valid held 3 cycles with stable operands; result high=2, low=14.
- Signed divide 0x8000_0000/0 -> divider_valid never asserted; result_valid in cycle 1 with high=0x8000_0000, low=0xFFFF_FFFF.
- Flush 5 cycles into DIV_WAIT, then a stale divider_result_valid 3 cycles later -> divider_abort is a single-cycle pulse; state IDLE; no result_valid; a new multiply is accepted normally afterwards.
- Backpressure in RESULT: result_ready=0 for 4 cycles while source1/source2 toggle -> result_high/low are unchanged, request_ready=0 and busy=1 throughout.
- Async reset asserted mid-MUL_WAIT, not aligned to a clock edge -> all outputs 0 immediately; after release, request_ready=1 in the first cycle.
